lap_stopwatch: RTL and testbench

Parametrised up/down stopwatch and countdown timer with lap/split capture, preset load and a completion pulse. It generalises the fixed 50 MHz, single-minute-digit stopwatch to any clock/tick rate and 1–2 minute digits, and feeds BCD digits to the seven-segment display driver. It is controlled directly by the UART command decoder.

---
 rtl/stopwatch_pkg.sv | 36 +++
 rtl/bcd_digit.sv | 39 +++
 rtl/lap_stopwatch.sv | 131 +++++++++++++
 tb/tb_lap_stopwatch.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: BCD digit type, per-digit
// moduli, FSM state encoding and the prescaler ratio helper.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   localparam int unsigned MOD_TENTHS   = 10;
   localparam int unsigned MOD_SEC_ONES = 10;
   localparam int unsigned MOD_SEC_TENS = 6;
   localparam int unsigned MOD_MIN      = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
   localparam int unsigned TICK_HZ_DEFAULT = 10;
   localparam int unsigned PRESCALE        = CLK_HZ_DEFAULT / TICK_HZ_DEFAULT;

   function automatic int unsigned prescale(input int unsigned clk_hz, input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Digit order is D, S0, S1, then one or more minute digits.
   function automatic int unsigned digit_mod(input int unsigned idx);
      case (idx)
         0:       return MOD_TENTHS;
         1:       return MOD_SEC_ONES;
         2:       return MOD_SEC_TENS;
         default: return MOD_MIN;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with programmable modulus, up/down stepping and
// synchronous clear/load; carry flags the roll-over value for the current direction.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int unsigned MOD = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic load,
   input  bcd_t load_val,
   input  logic en,
   input  logic up,
   output bcd_t digit,
   output logic carry
);

   localparam bcd_t TOP = bcd_t'(MOD - 1);

   // Unqualified by en so the parent can also use it for limit detection.
   assign carry = up ? (digit == TOP) : (digit == 4'd0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, regardless of process ordering in simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= 4'd0;
      end else if (clr) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= load_val;
      end else if (en) begin
         if (up) digit <= (digit == TOP)  ? 4'd0 : digit + 4'd1;
         else    digit <= (digit == 4'd0) ? TOP  : digit - 4'd1;
      end
   end

endmodule

// File: rtl/lap_stopwatch.sv
// Up/down stopwatch and countdown timer with lap hold, preset load and a
// completion pulse; drives BCD digits {M.., S1, S0, D} to the display.
module lap_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TICK_HZ    = 10,
   parameter int unsigned MIN_DIGITS = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          go,
   input  logic                          up,
   input  logic                          clr,
   input  logic                          load,
   input  logic [4*(3+MIN_DIGITS)-1:0]   preset_bcd,
   input  logic                          lap,
   output logic [4*(3+MIN_DIGITS)-1:0]   disp_bcd,
   output logic                          running,
   output logic                          lap_active,
   output logic                          done,
   output logic                          load_err
);

   localparam int unsigned NDIG  = 3 + MIN_DIGITS;
   localparam int unsigned W     = 4 * NDIG;
   localparam int unsigned PRESC = prescale(CLK_HZ, TICK_HZ);
   localparam int unsigned PW    = $clog2(PRESC);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q;
   logic [W-1:0]    count;
   logic [W-1:0]    lap_q;
   logic [NDIG-1:0] at_end;
   logic [NDIG-1:0] en_chain;
   logic            preset_ok, load_ok, tick, step, at_limit, near_limit, hit;

   always_comb begin
      preset_ok = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (preset_bcd[4*i +: 4] >= 4'(digit_mod(i))) preset_ok = 1'b0;
      end
   end

   assign load_ok    = load & preset_ok;
   assign tick       = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign at_limit   = &at_end;
   // One step away from the limit: all upper digits at their end value and D one short.
   assign near_limit = (&at_end[NDIG-1:1]) && (count[3:0] == (up ? 4'd8 : 4'd1));
   assign step       = tick & ~at_limit & ~clr & ~load_ok;

   for (genvar i = 0; i < NDIG; i++) begin : g_digit
      if (i == 0) begin : g_lsd
         assign en_chain[i] = step;
      end else begin : g_upper
         assign en_chain[i] = en_chain[i-1] & at_end[i-1];
      end

      bcd_digit #(
         .MOD(digit_mod(i))
      ) u_digit (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .load     (load_ok),
         .load_val (preset_bcd[4*i +: 4]),
         .en       (en_chain[i]),
         .up       (up),
         .digit    (count[4*i +: 4]),
         .carry    (at_end[i])
      );
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      if (clr || load_ok) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (go && !at_limit) state_d = ST_RUN;
            ST_RUN: begin
               if (tick && (at_limit || near_limit)) begin
                  state_d = ST_DONE;
                  hit     = 1'b1;
               end else if (!go) begin
                  state_d = ST_IDLE;
               end
            end
            ST_DONE: if (!go) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         presc_q  <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         done     <= hit;
         load_err <= load & ~preset_ok & ~clr;
         if (clr || load_ok)         presc_q <= '0;
         else if (state_q == ST_RUN) presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   // Lap capture uses the pre-tick count because count updates on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q      <= '0;
         lap_active <= 1'b0;
      end else if (clr) begin
         lap_q      <= '0;
         lap_active <= 1'b0;
      end else if (lap) begin
         if (!lap_active) lap_q <= count;
         lap_active <= ~lap_active;
      end
   end

   assign running  = (state_q == ST_RUN);
   assign disp_bcd = lap_active ? lap_q : count;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch: a tenths-of-a-second integer model
// tracks count, prescaler, mode and lap hold; directed scenarios plus random traffic.
module tb_lap_stopwatch;

   localparam int P      = 10;
   localparam int MAX_T  = 5999;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_DONE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        go = 1'b0;
   logic        up = 1'b1;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic        lap = 1'b0;
   logic [15:0] preset_bcd = 16'h0000;
   logic [15:0] disp_bcd;
   logic        running, lap_active, done, load_err;

   int checks = 0;
   int failures = 0;

   int m_cnt, m_presc, m_state, m_lap_val;
   bit m_lap_act, m_done, m_err;

   always #5 clk = ~clk;

   lap_stopwatch #(
      .CLK_HZ(10), .TICK_HZ(1), .MIN_DIGITS(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .up(up), .clr(clr), .load(load),
      .preset_bcd(preset_bcd), .lap(lap), .disp_bcd(disp_bcd), .running(running),
      .lap_active(lap_active), .done(done), .load_err(load_err)
   );

   function automatic logic [15:0] to_bcd(input int t);
      int m, s;
      m = t / 600;
      s = (t / 10) % 60;
      return {4'(m), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
   endfunction

   function automatic int from_bcd(input logic [15:0] b);
      int d, s0, s1, m;
      d = int'(b[3:0]); s0 = int'(b[7:4]); s1 = int'(b[11:8]); m = int'(b[15:12]);
      if (d > 9 || s0 > 9 || s1 > 5 || m > 9) return -1;
      return m * 600 + s1 * 100 + s0 * 10 + d;
   endfunction

   function automatic logic [19:0] exp_vec();
      return {to_bcd(m_lap_act ? m_lap_val : m_cnt), (m_state == S_RUN), m_lap_act, m_done, m_err};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {disp_bcd, running, lap_active, done, load_err};
   endfunction

   task automatic m_reset();
      m_cnt = 0; m_presc = 0; m_state = S_IDLE; m_lap_val = 0;
      m_lap_act = 0; m_done = 0; m_err = 0;
   endtask

   // Applies the behavioural rules to the inputs present at this clock edge.
   task automatic model_edge();
      int  lim, pv;
      bit  at_lim, tick;
      lim    = up ? MAX_T : 0;
      at_lim = (m_cnt == lim);
      tick   = (m_state == S_RUN) && (m_presc == P - 1);
      pv     = from_bcd(preset_bcd);
      m_done = 0;
      m_err  = 0;
      if (clr) begin
         m_lap_act = 0; m_lap_val = 0;
      end else if (lap) begin
         if (!m_lap_act) begin m_lap_val = m_cnt; m_lap_act = 1; end
         else m_lap_act = 0;
      end
      if (clr) begin
         m_cnt = 0; m_presc = 0; m_state = S_IDLE;
      end else if (load && pv >= 0) begin
         m_cnt = pv; m_presc = 0; m_state = S_IDLE;
      end else begin
         if (load) m_err = 1;
         case (m_state)
            S_IDLE: if (go && !at_lim) m_state = S_RUN;
            S_RUN: begin
               m_presc = tick ? 0 : m_presc + 1;
               if (tick && !at_lim) m_cnt = up ? m_cnt + 1 : m_cnt - 1;
               if (tick && m_cnt == lim) begin m_state = S_DONE; m_done = 1; end
               else if (!go) m_state = S_IDLE;
            end
            default: if (!go) m_state = S_IDLE;
         endcase
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (dut_vec() !== 20'h0) begin
         failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 20'h0);
      end
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      m_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_up_limit();
      int done_cnt = 0;
      bit seen10 = 0, seen600 = 0;
      up = 1; go = 1;
      for (int i = 0; i < 60100 && done_cnt == 0 && failures < 100; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL up_run got=%h exp=%h", dut_vec(), exp_vec());
         end
         if (done === 1'b1) done_cnt++;
         if (!seen10 && m_cnt == 10) begin
            seen10 = 1; checks++;
            if (disp_bcd !== 16'h0010) begin
               failures++; $display("FAIL roll_tenths got=%h exp=0010", disp_bcd);
            end
         end
         if (!seen600 && m_cnt == 600) begin
            seen600 = 1; checks++;
            if (disp_bcd !== 16'h1000) begin
               failures++; $display("FAIL roll_minute got=%h exp=1000", disp_bcd);
            end
         end
      end
      checks++;
      if (done_cnt == 0 || disp_bcd !== 16'h9599 || running !== 1'b0) begin
         failures++;
         $display("FAIL up_limit done_seen=%0d disp=%h running=%b exp done_seen=1 disp=9599 running=0",
                  done_cnt, disp_bcd, running);
      end
      for (int i = 0; i < 50 * P; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec() || disp_bcd !== 16'h9599) begin
            failures++; $display("FAIL limit_hold got=%h exp=%h", dut_vec(), exp_vec());
         end
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 1) begin
         failures++; $display("FAIL done_once got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_countdown();
      int r0 = -1, d0 = -1;
      go = 0; up = 0; preset_bcd = 16'h0012; load = 1;
      cyc(); load = 0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL cd_load got=%h exp=%h", dut_vec(), exp_vec());
      end
      go = 1;
      for (int i = 0; i < 200 && d0 < 0; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL cd_run got=%h exp=%h", dut_vec(), exp_vec());
         end
         if (r0 < 0 && running === 1'b1) r0 = i;
         if (done === 1'b1) d0 = i;
      end
      checks++;
      if (r0 < 0 || d0 < 0 || d0 - r0 != 12 * P || disp_bcd !== 16'h0000 || running !== 1'b0) begin
         failures++;
         $display("FAIL cd_done cycles=%0d disp=%h running=%b exp cycles=%0d disp=0000 running=0",
                  d0 - r0, disp_bcd, running, 12 * P);
      end
      go = 0; cyc(); go = 1;
      for (int i = 0; i < 5; i++) cyc();
      checks++;
      if (running !== 1'b0 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL cd_rego running=%b exp=0", running);
      end
   endtask

   task automatic test_lap();
      go = 0; up = 1; clr = 1; cyc(); clr = 0; go = 1;
      for (int i = 0; i < 500 && disp_bcd !== 16'h0034; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL lap_run got=%h exp=%h", dut_vec(), exp_vec());
         end
      end
      checks++;
      if (disp_bcd !== 16'h0034) begin
         failures++; $display("FAIL lap_reach got=%h exp=0034", disp_bcd);
      end
      lap = 1; cyc(); lap = 0;
      checks++;
      if (lap_active !== 1'b1 || disp_bcd !== 16'h0034) begin
         failures++; $display("FAIL lap_capture disp=%h act=%b exp disp=0034 act=1", disp_bcd, lap_active);
      end
      for (int i = 0; i < 500 && m_cnt != 70; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec() || disp_bcd !== 16'h0034) begin
            failures++; $display("FAIL lap_frozen got=%h exp=%h", dut_vec(), exp_vec());
         end
      end
      lap = 1; cyc(); lap = 0;
      checks++;
      if (lap_active !== 1'b0 || disp_bcd !== 16'h0070) begin
         failures++; $display("FAIL lap_release disp=%h act=%b exp disp=0070 act=0", disp_bcd, lap_active);
      end
      lap = 1; cyc(); lap = 0;
      clr = 1; cyc(); clr = 0;
      checks++;
      if (disp_bcd !== 16'h0000 || lap_active !== 1'b0 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL lap_clr got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_pause();
      logic [15:0] frozen;
      int n = -1;
      go = 0; clr = 1; cyc(); clr = 0; up = 1; go = 1;
      for (int i = 0; i < 100 && !(m_state == S_RUN && m_presc == 5 && m_cnt >= 2); i++) cyc();
      go = 0; cyc();
      frozen = to_bcd(m_cnt);
      for (int i = 0; i < 100; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec() || disp_bcd !== frozen) begin
            failures++; $display("FAIL pause_hold got=%h exp=%h", disp_bcd, frozen);
         end
      end
      go = 1; cyc();
      checks++;
      if (running !== 1'b1) begin
         failures++; $display("FAIL go_latency running=%b exp=1", running);
      end
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (disp_bcd !== frozen) begin n = i; break; end
      end
      checks++;
      if (n != 4 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL resume_tick cycles=%0d exp=4 disp=%h exp_disp=%h", n, disp_bcd, to_bcd(m_cnt));
      end
   endtask

   task automatic test_simultaneous();
      go = 0; clr = 1; cyc(); clr = 0; up = 1; go = 1;
      for (int i = 0; i < 100 && !(m_state == S_RUN && m_presc == P - 1 && m_cnt >= 3); i++) cyc();
      clr = 1; load = 1; preset_bcd = 16'h0123; cyc(); clr = 0; load = 0;
      checks++;
      if (disp_bcd !== 16'h0000 || running !== 1'b0 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL clr_load_tick got=%h exp=%h", dut_vec(), exp_vec());
      end
      go = 0; preset_bcd = 16'h0255; load = 1; cyc(); load = 0;
      preset_bcd = 16'h0712; load = 1; cyc(); load = 0;
      checks++;
      if (load_err !== 1'b1 || disp_bcd !== 16'h0255) begin
         failures++; $display("FAIL bad_preset err=%b disp=%h exp err=1 disp=0255", load_err, disp_bcd);
      end
      cyc();
      checks++;
      if (load_err !== 1'b0 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL err_pulse got=%h exp=%h", dut_vec(), exp_vec());
      end
      preset_bcd = 16'h0048; load = 1; cyc(); load = 0; up = 1; go = 1;
      for (int i = 0; i < 100 && disp_bcd !== 16'h0050; i++) cyc();
      checks++;
      if (disp_bcd !== 16'h0050) begin
         failures++; $display("FAIL flip_reach got=%h exp=0050", disp_bcd);
      end
      up = 0;
      for (int i = 0; i < 30 && disp_bcd === 16'h0050; i++) cyc();
      checks++;
      if (disp_bcd !== 16'h0049 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL dir_flip got=%h exp=0049", disp_bcd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         go   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) up = ~up;
         clr  = ($urandom_range(0, 199) == 0);
         load = ($urandom_range(0, 99) == 0);
         lap  = ($urandom_range(0, 29) == 0);
         preset_bcd = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, MAX_T)) : 16'($urandom);
         cyc(); checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
      end
      clr = 0; load = 0; lap = 0;
   endtask

   task automatic test_reset_mid();
      go = 0; clr = 1; cyc(); clr = 0; up = 1; go = 1;
      for (int i = 0; i < 25; i++) cyc();
      lap = 1; cyc(); lap = 0;
      for (int i = 0; i < 5; i++) cyc();
      #2 rst_n = 1'b0;
      #1 m_reset();
      checks++;
      if (dut_vec() !== 20'h0) begin
         failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), 20'h0);
      end
      go = 0;
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      go = 1;
      for (int i = 0; i < 40; i++) begin
         cyc(); checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL post_reset got=%h exp=%h", dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_up_limit();
      test_countdown();
      test_lap();
      test_pause();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
